// File: rtl/stripe_timebase_ctrl.sv
// Stripe display timebase: period divider, tick/blink generation,
// pattern index sequencing and run-time period reconfiguration.
module stripe_timebase_ctrl #(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 60000000,
  parameter int NUM_PATTERNS   = 8,
  parameter int IDX_W          = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_ready,
  output logic             tick,
  output logic [IDX_W-1:0] pattern_idx,
  output logic             blink,
  output logic             frame_done,
  output logic             running,
  output logic [CNT_W-1:0] period_active
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_PATTERNS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] pa_n;
  logic [CNT_W-1:0] pend, pend_n;
  logic             pend_v, pend_v_n;
  logic [CNT_W-1:0] cfg_val;
  logic             accept;
  logic             term;
  logic             tick_ev;

  assign accept  = cfg_valid && cfg_ready;
  assign cfg_val = (cfg_period == '0) ? ONE : cfg_period;
  assign term    = (state == RUN) && (count == period_active - ONE);

  always_comb begin
    state_n  = state;
    count_n  = count;
    pa_n     = period_active;
    pend_n   = pend;
    pend_v_n = pend_v;
    tick_ev  = 1'b0;
    unique case (state)
      IDLE: begin
        count_n = '0;
        if (accept) pa_n = cfg_val;
        if (start && !stop) state_n = RUN;
        else if (step && !start) tick_ev = 1'b1;
      end
      RUN: begin
        tick_ev = term;
        count_n = term ? '0 : count + ONE;
        if (accept) begin
          pend_v_n = 1'b1;
          pend_n   = cfg_val;
        end
        // A queued period only lands on a period boundary or on stop.
        if (term && pend_v) begin
          pa_n     = pend;
          pend_v_n = 1'b0;
        end
        if (stop) begin
          state_n = IDLE;
          count_n = '0;
          if (pend_v_n) begin
            pa_n     = pend_n;
            pend_v_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      period_active <= DEF_P;
      pend          <= '0;
      pend_v        <= 1'b0;
      cfg_ready     <= 1'b1;
      tick          <= 1'b0;
      frame_done    <= 1'b0;
      blink         <= 1'b0;
      pattern_idx   <= '0;
      running       <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      period_active <= pa_n;
      pend          <= pend_n;
      pend_v        <= pend_v_n;
      cfg_ready     <= !pend_v_n;
      running       <= (state_n == RUN);
      tick          <= tick_ev;
      frame_done    <= tick_ev && (pattern_idx == LAST);
      if (tick_ev) begin
        blink       <= !blink;
        pattern_idx <= (pattern_idx == LAST) ? '0 : pattern_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/stripe_timebase_ctrl.md
Name: stripe_timebase_ctrl

Overview:
Controller for the stripe display timebase. It owns a programmable period divider, issues a one-cycle tick every period, and sequences a stripe pattern index through NUM_PATTERNS states. It provides start/stop/single-step control and a valid/ready handshake for reconfiguring the period at run time. It sits between the top-level control logic and the VGA stripe pattern generator, which consumes pattern_idx, tick and blink.

Parameters:
CNT_W, 26, width of the period counter and of cfg_period
DEFAULT_PERIOD, 60000000, period in clk1 cycles loaded at reset
NUM_PATTERNS, 8, number of pattern indices; the index counts 0..NUM_PATTERNS-1
IDX_W, 3, width of pattern_idx; must satisfy 2^IDX_W >= NUM_PATTERNS

Ports:
clk1  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  level-sampled; begin free-running ticks
stop  input  1  level-sampled; halt ticks and return to IDLE
step  input  1  in IDLE only: issue one tick
cfg_valid  input  1  new period offered
cfg_period  input  CNT_W  offered period in cycles
cfg_ready  output  1  controller can accept a period
tick  output  1  one-cycle pulse per period
pattern_idx  output  IDX_W  current stripe pattern
blink  output  1  toggles on every tick
frame_done  output  1  one-cycle pulse when pattern_idx wraps to 0
running  output  1  high in RUN
period_active  output  CNT_W  period currently in use

Behaviour:
- Decided: one clock, clk1; rst is synchronous and active-high.
- Reset values: state=IDLE, count=0, period_active=DEFAULT_PERIOD, pending cleared, tick=0, frame_done=0, blink=0, pattern_idx=0, running=0, cfg_ready=1.
- rst overrides all other inputs in the same cycle. Reset mid-run discards any pending configuration.
- All outputs are registered.
- A "tick event" updates three things together:
  - pattern_idx: +1, wrapping from NUM_PATTERNS-1 to 0; frame_done=1 for that cycle on the wrap.
  - blink: toggles.
  - tick: 1 for exactly one cycle.
- States:
  - IDLE: count held at 0, running=0.
    - start → RUN.
    - step (with start low) → tick event in the next cycle; state stays IDLE.
  - RUN: running=1, count increments each cycle.
    - When count==period_active-1: count→0 and a tick event occurs in the next cycle.
    - stop → IDLE; count→0; pattern_idx and blink are retained.
- Simultaneous events:
  - start and stop together: stop wins.
  - start and step together in IDLE: start wins; step is ignored.
  - step in RUN: ignored.
  - stop on a terminal-count cycle: the tick event is still issued, then the state is IDLE.
- Tick latency: start sampled at edge 0 → running=1 after edge 0. The first tick is high between edges P and P+1; later ticks follow every P cycles.
- Configuration handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pending_valid.
  - cfg_period=0 is stored as 1.
  - In IDLE: period_active takes the new value on the next edge; nothing is held pending.
  - In RUN: the value is held in pending and cfg_ready drops. At the terminal-count edge, period_active←pending, pending is cleared, and count restarts at 0. The current period is never truncated or stretched.
  - stop while pending in RUN: pending is applied on the transition to IDLE.
- Period 1: tick is high every cycle while in RUN; blink toggles every cycle.

Test Plan:
(Bench uses DEFAULT_PERIOD=4, NUM_PATTERNS=4, CNT_W=8.)
- Reset then idle 20 cycles → tick=0, pattern_idx=0, blink=0, running=0, cfg_ready=1, period_active=4.
- start pulse at edge 0 → tick high after edges 4, 8, 12, 16; pattern_idx steps 1,2,3,0; frame_done high only with the 4th tick; blink reads 1,0,1,0.
- In RUN at count=1, offer cfg_period=2 → cfg_ready low next cycle; the current tick still lands at the 4-cycle boundary; ticks every 2 cycles afterwards; cfg_ready returns to 1.
- stop asserted on a terminal-count cycle → that tick is still issued, running=0 next cycle, no further ticks, pattern_idx retained. Then step → exactly one tick, pattern_idx +1.
- start and stop high together in IDLE → stays IDLE. cfg_period=0 in IDLE → period_active=1; start → tick high every cycle.
- rst asserted mid-RUN with a pending config → all outputs return to reset values next cycle; period_active=4 and the pending value is discarded.
